// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//
// Instruction fetch stage. Holds the program counter, drives the word address
// into a combinational instruction memory, buffers each returned word tagged
// with its byte PC in a small FIFO, and hands entries to decode over a
// valid/ready handshake. Downstream redirects reload the PC and flush the
// FIFO; fetching stops when the halt sentinel word is read.
//
// Ports:
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous, active-low reset
//   imem_a         out  6   word address to instruction memory (pc[7:2])
//   imem_rd        in  32   instruction word for imem_a, same cycle
//   out_valid      out  1   FIFO head valid
//   out_ready      in   1   decode accepts the head entry
//   out_instr      out 32   head instruction (0 while empty)
//   out_pc         out 32   byte PC of head instruction (0 while empty)
//   redirect_valid in   1   load redirect_pc and flush the FIFO
//   redirect_pc    in  32   redirect target byte address
//   halted         out  1   fetch stopped on HALT_WORD
//   misalign_err   out  1   sticky: a redirect target had nonzero bits [1:0]
//   fetch_cnt      out 32   words pushed into the FIFO, wraps mod 2^32
// ---------------------------------------------------------------------------
module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [5:0]  imem_a,
    input  logic [31:0] imem_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [31:0]        pc;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [31:0]        mem_instr [DEPTH];
    logic [31:0]        mem_pc    [DEPTH];

    logic pop;
    logic fetch_slot;
    logic halt_hit;
    logic push;

    // A redirect cancels both sides of the FIFO for this edge. A full FIFO
    // still accepts a word when the head leaves in the same cycle.
    always_comb begin
        pop        = out_valid & out_ready & ~redirect_valid;
        fetch_slot = ~redirect_valid & (state == RUN) & ((count < DEPTH_CNT) | pop);
        halt_hit   = fetch_slot & (imem_rd == HALT_WORD);
        push       = fetch_slot & (imem_rd != HALT_WORD);
    end

    // NOTE: next-state logic assigns its default first so no path leaves
    // state_next unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = RUN;
        end else if (halt_hit) begin
            state_next = HALT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            misalign_err <= 1'b0;
            fetch_cnt    <= '0;
        end else if (redirect_valid) begin
            pc     <= {redirect_pc[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_err <= 1'b1;
            end
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                pc        <= pc + 32'd4;
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // NOTE: FIFO storage has no reset; its contents are never observed until
    // written, because the outputs are masked to zero while count is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= imem_rd;
            mem_pc[wr_ptr]    <= pc;
        end
    end

    always_comb begin
        imem_a    = pc[7:2];
        halted    = (state == HALT);
        out_valid = (count != '0);
        out_instr = out_valid ? mem_instr[rd_ptr] : 32'h0;
        out_pc    = out_valid ? mem_pc[rd_ptr]    : 32'h0;
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit
//
// Self-checking bench for ifetch_unit. A behavioural model (a queue of
// {pc, instr} entries plus PC/halt/error/count variables) is stepped once per
// clock and compared with every DUT output one time unit after each edge.
// Directed steps follow the fetch scenarios; a randomized phase then mixes
// backpressure and redirects.
// ---------------------------------------------------------------------------
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          DEPTH     = 2;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic [5:0]  imem_a;
    logic [31:0] imem_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic        misalign_err;
    logic [31:0] fetch_cnt;

    ifetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .HALT_WORD(HALT_WORD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_a        (imem_a),
        .imem_rd       (imem_rd),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halted        (halted),
        .misalign_err  (misalign_err),
        .fetch_cnt     (fetch_cnt)
    );

    // Instruction memory: combinational read.
    logic [31:0] mem [64];
    assign imem_rd = mem[imem_a];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] mpc;
    bit          mhalt;
    bit          mmis;
    logic [31:0] mcnt;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc   = RESET_PC;
        mhalt = 1'b0;
        mmis  = 1'b0;
        mcnt  = 32'd0;
    endtask

    // One clock edge of the fetch stage, from the rules in plain terms.
    task automatic model_step();
        entry_t      e;
        bit          pop;
        bit          slot;
        logic [31:0] w;
        if (redirect_valid) begin
            mq.delete();
            mpc   = {redirect_pc[31:2], 2'b00};
            mhalt = 1'b0;
            if (redirect_pc[1:0] != 2'b00) mmis = 1'b1;
        end else begin
            pop  = (mq.size() > 0) && out_ready;
            slot = !mhalt && ((mq.size() < DEPTH) || pop);
            w    = mem[mpc[7:2]];
            if (pop) void'(mq.pop_front());
            if (slot) begin
                if (w == HALT_WORD) begin
                    mhalt = 1'b1;
                end else begin
                    e.pc    = mpc;
                    e.instr = w;
                    mq.push_back(e);
                    mpc  = mpc + 32'd4;
                    mcnt = mcnt + 32'd1;
                end
            end
        end
    endtask

    task automatic check_all(input string where);
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        exp_pc    = (mq.size() > 0) ? mq[0].pc    : 32'h0;
        exp_instr = (mq.size() > 0) ? mq[0].instr : 32'h0;
        check({where, ".out_valid"},    32'(out_valid),    32'(mq.size() > 0));
        check({where, ".out_pc"},       out_pc,            exp_pc);
        check({where, ".out_instr"},    out_instr,         exp_instr);
        check({where, ".imem_a"},       32'(imem_a),       32'(mpc[7:2]));
        check({where, ".halted"},       32'(halted),       32'(mhalt));
        check({where, ".misalign_err"}, 32'(misalign_err), 32'(mmis));
        check({where, ".fetch_cnt"},    fetch_cnt,         mcnt);
    endtask

    task automatic tick(input string where);
        model_step();
        @(posedge clk);
        #1;
        check_all(where);
    endtask

    // Called 1 time unit after an edge; asserts reset between edges and
    // checks the reset values before any further clock edge.
    task automatic async_reset(input string where);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(where);
        check({where, ".rst_out_valid"}, 32'(out_valid), 32'd0);
        check({where, ".rst_imem_a"},    32'(imem_a),    32'(RESET_PC[7:2]));
        check({where, ".rst_fetch_cnt"}, fetch_cnt,      32'd0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Memory image: random non-halt words, fixed program at 0..2,
        // halt sentinel at word 18.
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            if (mem[i] == HALT_WORD) mem[i] = 32'h0000_0000;
        end
        mem[0]  = 32'h2001_0007;
        mem[1]  = 32'h2002_0008;
        mem[2]  = 32'h2004_000F;
        mem[18] = HALT_WORD;

        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Power-on reset with a real falling edge.
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        #1;
        rst_n = 1'b1;

        // Reset and stream.
        tick("stream1");
        check("stream1.pc", out_pc, 32'h0);
        check("stream1.instr", out_instr, 32'h2001_0007);
        tick("stream2");
        check("stream2.pc", out_pc, 32'h4);
        tick("stream3");
        check("stream3.pc", out_pc, 32'h8);
        check("stream3.cnt", fetch_cnt, 32'd3);

        // Fill the FIFO, then reset asynchronously mid-stream.
        out_ready = 1'b0;
        tick("fill1");
        tick("fill2");
        async_reset("async_rst");

        // Backpressure from reset.
        for (int i = 0; i < 5; i++) tick("bp_hold");
        check("bp.imem_a", 32'(imem_a), 32'd2);
        check("bp.head", out_pc, 32'h0);
        check("bp.cnt", fetch_cnt, 32'd2);
        out_ready = 1'b1;
        tick("bp_rel1");
        check("bp_rel1.pc", out_pc, 32'h4);
        tick("bp_rel2");
        check("bp_rel2.pc", out_pc, 32'h8);
        tick("bp_rel3");
        check("bp_rel3.pc", out_pc, 32'hC);

        // Redirect with a full FIFO while decode is accepting.
        out_ready = 1'b0;
        tick("rd_fill1");
        tick("rd_fill2");
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h44;
        tick("redir");
        redirect_valid = 1'b0;
        check("redir.valid", 32'(out_valid), 32'd0);
        check("redir.imem_a", 32'(imem_a), 32'd17);
        tick("redir2");
        check("redir2.pc", out_pc, 32'h44);
        tick("redir_halt");
        check("redir_halt.halted", 32'(halted), 32'd1);

        // Halt with entries buffered: they still drain.
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick("h_redir");
        redirect_valid = 1'b0;
        tick("h_fill1");
        tick("h_fill2");
        tick("h_full");
        check("h_full.halted", 32'(halted), 32'd0);
        out_ready = 1'b1;
        tick("h_hit");
        check("h_hit.halted", 32'(halted), 32'd1);
        check("h_hit.head", out_pc, 32'h44);
        check("h_hit.imem_a", 32'(imem_a), 32'd18);
        for (int i = 0; i < 4; i++) tick("h_idle");
        check("h_idle.valid", 32'(out_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h48;
        tick("h_r48");
        redirect_valid = 1'b0;
        check("h_r48.halted", 32'(halted), 32'd0);
        tick("h_r48b");
        check("h_r48b.halted", 32'(halted), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick("h_r0");
        redirect_valid = 1'b0;
        check("h_r0.halted", 32'(halted), 32'd0);
        tick("h_r0b");
        check("h_r0b.pc", out_pc, 32'h0);

        // Misaligned redirect: sticky error, word-aligned target.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h16;
        tick("mis");
        check("mis.imem_a", 32'(imem_a), 32'd5);
        check("mis.err", 32'(misalign_err), 32'd1);
        redirect_valid = 1'b0;
        tick("mis2");
        check("mis2.pc", out_pc, 32'h14);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        tick("mis_ok");
        redirect_valid = 1'b0;
        check("mis_ok.err", 32'(misalign_err), 32'd1);

        // Full 32-bit PC wrap and imem_a wrap.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick("wrap");
        redirect_valid = 1'b0;
        check("wrap.imem_a", 32'(imem_a), 32'd63);
        tick("wrap2");
        check("wrap2.pc", out_pc, 32'hFFFF_FFFC);
        check("wrap2.imem_a", 32'(imem_a), 32'd0);
        tick("wrap3");
        check("wrap3.pc", out_pc, 32'h0);

        // Reset clears the sticky error.
        async_reset("mis_rst");
        check("mis_rst.err", 32'(misalign_err), 32'd0);

        // Randomized backpressure and redirects.
        for (int i = 0; i < 400; i++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 1)
                redirect_pc = $urandom;
            else
                redirect_pc = 32'($urandom_range(32'h38, 32'h4F));
            tick("rand");
        end
        redirect_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
